// File: rtl/ro_buffer_mc.sv
// Reorder buffer with multi-port write-back, operand bypass and up to two
// in-order commits per cycle. Entry IDs run 1..DEPTH; ID 0 means "none".
// Branch mispredicts raise a one-cycle flush pulse that clears the buffer
// on the following edge.

`ifndef ISSUER_TO_ROB_SIGNAL_TYPE
`define ISSUER_TO_ROB_SIGNAL_TYPE logic [1:0]
`endif

module ro_buffer_mc #(
    parameter int DEPTH    = 16,
    parameter int ID_W     = 5,
    parameter int NUM_WB   = 2,
    parameter int COMMIT_W = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rdy,
    input  logic                               flush_in,
    output logic                               full,
    output logic [ID_W:0]                      count,
    input  logic                               iss_valid,
    input  `ISSUER_TO_ROB_SIGNAL_TYPE          iss_signal,
    input  logic [4:0]                         iss_rd,
    input  logic [31:0]                        iss_pc,
    input  logic [31:0]                        iss_npc,
    output logic [ID_W-1:0]                    iss_dest,
    input  logic [ID_W-1:0]                    qj,
    input  logic [ID_W-1:0]                    qk,
    output logic                               vj_ok,
    output logic                               vk_ok,
    output logic [31:0]                        vj,
    output logic [31:0]                        vk,
    input  logic [NUM_WB-1:0][ID_W-1:0]        wb_dest,
    input  logic [NUM_WB-1:0][31:0]            wb_value,
    input  logic [NUM_WB-1:0][31:0]            wb_npc,
    output logic [COMMIT_W-1:0][ID_W-1:0]      cm_dest,
    output logic [COMMIT_W-1:0][4:0]           cm_rd,
    output logic [COMMIT_W-1:0][31:0]          cm_value,
    output logic [ID_W-1:0]                    st_dest,
    output logic                               br_valid,
    output logic [31:0]                        br_pc,
    output logic                               br_taken,
    output logic                               flush_out,
    output logic [31:0]                        flush_pc
);

    localparam int CW = ID_W + 1;
    localparam logic [1:0] SIG_STORE  = 2'd2;
    localparam logic [1:0] SIG_BRANCH = 2'd3;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [1:0]  sig;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] npc;    // predicted next PC
        logic [31:0] value;
        logic [31:0] rnpc;   // resolved next PC
    } ent_t;

    ent_t            ent [DEPTH];
    logic [ID_W-1:0] head, tail;

    // per-entry write-back match (lowest port wins on equal tags)
    logic            hit [DEPTH];
    logic [31:0]     hv  [DEPTH];
    logic [31:0]     hn  [DEPTH];

    // head / head+1 views
    ent_t            h0;
    logic [ID_W-1:0] head1;
    logic            h1_valid, h1_ready;
    logic [1:0]      h1_sig;
    logic [4:0]      h1_rd;
    logic [31:0]     h1_value;

    logic            c0, c1, issue, br_fire, mispred;
    logic [1:0]      n_cm;
    logic [1:0][ID_W-1:0] sd;
    logic [1:0][4:0]      sr;
    logic [1:0][31:0]     sv;

    function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] id);
        return (id == ID_W'(DEPTH)) ? ID_W'(1) : id + ID_W'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign iss_dest = tail;
    assign head1    = nxt(head);
    assign issue    = iss_valid && !full;

    // match every entry against all write-back ports; scan high-to-low so port 0 has the last word
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = 1'b0;
            hv[i]  = '0;
            hn[i]  = '0;
            for (int k = NUM_WB - 1; k >= 0; k--) begin
                if (wb_dest[k] == ID_W'(i + 1)) begin
                    hit[i] = 1'b1;
                    hv[i]  = wb_value[k];
                    hn[i]  = wb_npc[k];
                end
            end
        end
    end

    // operand lookup: stored ready value first, then same-cycle bypass
    always_comb begin
        vj_ok = 1'b0;
        vj    = '0;
        vk_ok = 1'b0;
        vk    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (qj == ID_W'(i + 1)) begin
                if (ent[i].valid && ent[i].ready) begin
                    vj_ok = 1'b1;
                    vj    = ent[i].value;
                end else if (hit[i]) begin
                    vj_ok = 1'b1;
                    vj    = hv[i];
                end
            end
            if (qk == ID_W'(i + 1)) begin
                if (ent[i].valid && ent[i].ready) begin
                    vk_ok = 1'b1;
                    vk    = ent[i].value;
                end else if (hit[i]) begin
                    vk_ok = 1'b1;
                    vk    = hv[i];
                end
            end
        end
    end

    // gather the two oldest entries for the commit decision
    always_comb begin
        h0       = '0;
        h1_valid = 1'b0;
        h1_ready = 1'b0;
        h1_sig   = '0;
        h1_rd    = '0;
        h1_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (head == ID_W'(i + 1)) h0 = ent[i];
            if (head1 == ID_W'(i + 1)) begin
                h1_valid = ent[i].valid;
                h1_ready = ent[i].ready;
                h1_sig   = ent[i].sig;
                h1_rd    = ent[i].rd;
                h1_value = ent[i].value;
            end
        end
    end

    // commit decision from registered readiness only; stores retire without a result
    always_comb begin
        c0 = h0.valid && (h0.sig == SIG_STORE || h0.ready);
        c1 = (COMMIT_W == 2) && c0
             && h0.sig != SIG_STORE && h0.sig != SIG_BRANCH
             && h1_valid && h1_ready
             && h1_sig != SIG_STORE && h1_sig != SIG_BRANCH;
        n_cm    = {1'b0, c0} + {1'b0, c1};
        br_fire = c0 && h0.sig == SIG_BRANCH;
        mispred = br_fire && (h0.rnpc != h0.npc);
        sd[0] = '0;
        sr[0] = '0;
        sv[0] = '0;
        if (c0 && h0.sig != SIG_STORE) begin
            sd[0] = head;
            sr[0] = h0.rd;
            sv[0] = h0.value;
        end
        sd[1] = c1 ? head1    : '0;
        sr[1] = c1 ? h1_rd    : '0;
        sv[1] = c1 ? h1_value : '0;
    end

    // state and registered commit outputs; reset/flush clears everything
    always_ff @(posedge clk) begin
        if (!rst || (rdy && (flush_in || flush_out))) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            head      <= ID_W'(1);
            tail      <= ID_W'(1);
            count     <= '0;
            cm_dest   <= '0;
            cm_rd     <= '0;
            cm_value  <= '0;
            st_dest   <= '0;
            br_valid  <= 1'b0;
            br_pc     <= '0;
            br_taken  <= 1'b0;
            flush_out <= 1'b0;
            flush_pc  <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue && tail == ID_W'(i + 1)) begin
                    ent[i].valid <= 1'b1;
                    ent[i].ready <= 1'b0;
                    ent[i].sig   <= iss_signal;
                    ent[i].rd    <= iss_rd;
                    ent[i].pc    <= iss_pc;
                    ent[i].npc   <= iss_npc;
                    ent[i].value <= '0;
                    ent[i].rnpc  <= '0;
                end else begin
                    if (hit[i] && ent[i].valid) begin
                        ent[i].ready <= 1'b1;
                        ent[i].value <= hv[i];
                        ent[i].rnpc  <= hn[i];
                    end
                    if ((c0 && head == ID_W'(i + 1)) || (c1 && head1 == ID_W'(i + 1)))
                        ent[i].valid <= 1'b0;
                end
            end
            head  <= c1 ? nxt(head1) : (c0 ? head1 : head);
            tail  <= issue ? nxt(tail) : tail;
            count <= count + CW'(issue) - CW'(n_cm);
            for (int s = 0; s < COMMIT_W; s++) begin
                cm_dest[s]  <= sd[s];
                cm_rd[s]    <= sr[s];
                cm_value[s] <= sv[s];
            end
            st_dest   <= (c0 && h0.sig == SIG_STORE) ? head : '0;
            br_valid  <= br_fire;
            br_pc     <= br_fire ? h0.pc : '0;
            br_taken  <= br_fire && (h0.rnpc != h0.pc + 32'd4);
            flush_out <= mispred;
            flush_pc  <= mispred ? h0.rnpc : '0;
        end
    end

endmodule
